// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
// Holds the FSM encoding, default memory window and the wait-counter width.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2,
      ST_ERR    = 2'd3
   } state_t;

   localparam int DEF_BASE_ADR  = 1024;
   localparam int DEF_MEM_BYTES = 1024;
   localparam int CNT_W         = 4;

   // Word-aligned and inside [lo, hi]; 33-bit compare so the window may end at 2**32-4.
   function automatic logic adr_legal(input logic [31:0] a,
                                      input logic [32:0] lo,
                                      input logic [32:0] hi);
      return ({1'b0, a} >= lo) && ({1'b0, a} <= hi) && (a[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin selector: a lone request wins outright, a tie goes to
// the requester that was not granted last. Purely combinational.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one single-ported data memory. Each access
// holds the memory enable for WAIT_CYCLES cycles, then pulses ready (and err on a bad address).
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int BASE_ADR    = DEF_BASE_ADR,
   parameter int MEM_BYTES   = DEF_MEM_BYTES,
   parameter int WAIT_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [1:0]  we,
   input  logic [63:0] adr,
   input  logic [63:0] wdata,
   output logic [1:0]  ready,
   output logic [1:0]  err,
   output logic [31:0] rdata,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_wdata,
   output logic        mem_r_en,
   output logic        mem_w_en,
   input  logic [31:0] mem_rdata
);

   localparam logic [32:0]      ADR_LO   = 33'(BASE_ADR);
   localparam logic [32:0]      ADR_HI   = 33'(BASE_ADR + MEM_BYTES - 4);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   state_t            state_reg;
   state_t            state_next;
   logic [CNT_W-1:0]  cnt_reg;
   logic              last_reg;
   logic              gnt_reg;
   logic              we_reg;
   logic [31:0]       adr_reg;
   logic [31:0]       wdata_reg;
   logic [31:0]       rdata_reg;

   logic [1:0]        grant;
   logic              sel;
   logic              accept;
   logic              legal;
   logic              resp;
   logic              err_any;
   logic [31:0]       adr_arr   [2];
   logic [31:0]       wdata_arr [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_unpack
         assign adr_arr[gi]   = adr[32*gi +: 32];
         assign wdata_arr[gi] = wdata[32*gi +: 32];
      end
   endgenerate

   rr_arb2 u_rr_arb2 (
      .req   (req),
      .last  (last_reg),
      .grant (grant)
   );

   assign sel    = grant[1];
   assign accept = (state_reg == ST_IDLE) && (|req);
   assign legal  = adr_legal(adr_arr[sel], ADR_LO, ADR_HI);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (accept) state_next = legal ? ST_ACCESS : ST_ERR;
         ST_ACCESS: if (cnt_reg == '0) state_next = ST_DONE;
         ST_DONE:   state_next = ST_IDLE;
         ST_ERR:    state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Request latch, wait counter, round-robin history and read-data capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg   <= '0;
         last_reg  <= 1'b1;
         gnt_reg   <= 1'b0;
         we_reg    <= 1'b0;
         adr_reg   <= '0;
         wdata_reg <= '0;
         rdata_reg <= '0;
      end else begin
         if (accept) begin
            gnt_reg   <= sel;
            last_reg  <= sel;
            we_reg    <= we[sel];
            adr_reg   <= adr_arr[sel];
            wdata_reg <= wdata_arr[sel];
            cnt_reg   <= legal ? CNT_LOAD : '0;
         end else if (state_reg == ST_ACCESS) begin
            if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
            else if (!we_reg)  rdata_reg <= mem_rdata;
         end
      end
   end

   always_comb begin
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      resp     = 1'b0;
      err_any  = 1'b0;
      case (state_reg)
         ST_ACCESS: begin
            mem_r_en = !we_reg;
            mem_w_en = we_reg;
         end
         ST_DONE: resp = 1'b1;
         ST_ERR: begin
            resp    = 1'b1;
            err_any = 1'b1;
         end
         default: ;
      endcase
   end

   generate
      for (gi = 0; gi < 2; gi++) begin : g_resp
         assign ready[gi] = resp    && (gnt_reg == 1'(gi));
         assign err[gi]   = err_any && (gnt_reg == 1'(gi));
      end
   endgenerate

   assign rdata     = rdata_reg;
   assign mem_adr   = adr_reg;
   assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a scoreboard of expected responses is filled
// as each request is driven and drained as ready pulses appear.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [63:0] adr;
   logic [63:0] wdata;
   logic [1:0]  ready;
   logic [1:0]  err;
   logic [31:0] rdata;
   logic [31:0] mem_adr;
   logic [31:0] mem_wdata;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] mem_rdata = '0;

   logic [31:0] mem [256];
   logic        preloaded = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      string       tag;
      logic [1:0]  rdy;
      logic [1:0]  er;
      logic [31:0] rd;
      int          lat;
      int          ren;
      int          wen;
   } exp_t;

   exp_t sb[$];

   logic [1:0] obs_rdy;
   logic [1:0] obs_err;
   int         obs_cyc;
   int         obs_ren;
   int         obs_wen;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .BASE_ADR    (1024),
      .MEM_BYTES   (1024),
      .WAIT_CYCLES (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .we        (we),
      .adr       (adr),
      .wdata     (wdata),
      .ready     (ready),
      .err       (err),
      .rdata     (rdata),
      .mem_adr   (mem_adr),
      .mem_wdata (mem_wdata),
      .mem_r_en  (mem_r_en),
      .mem_w_en  (mem_w_en),
      .mem_rdata (mem_rdata)
   );

   // Memory model: word 1 (address 1028) preloaded, reads update on negedge.
   always @(posedge clk) begin
      if (!preloaded) begin
         mem[1]    <= 32'hDEADBEEF;
         preloaded <= 1'b1;
      end else if (mem_w_en) begin
         mem[mem_adr[9:2]] <= mem_wdata;
      end
   end

   always @(negedge clk) begin
      if (mem_r_en) mem_rdata <= mem[mem_adr[9:2]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic [1:0] rdy, input logic [1:0] er,
                           input logic [31:0] rd, input int lat, input int ren, input int wen);
      exp_t e;
      e.tag = tag; e.rdy = rdy; e.er = er; e.rd = rd;
      e.lat = lat; e.ren = ren; e.wen = wen;
      sb.push_back(e);
   endtask

   task automatic drive_one(input int idx, input logic w, input logic [31:0] a, input logic [31:0] d);
      req = 2'b00;
      req[idx] = 1'b1;
      we[idx] = w;
      adr[32*idx +: 32] = a;
      wdata[32*idx +: 32] = d;
   endtask

   // Called at a negedge; returns at the negedge where ready pulses (or after a 40-cycle budget).
   task automatic wait_ready();
      obs_rdy = 2'b00; obs_err = 2'b00;
      obs_cyc = 0; obs_ren = 0; obs_wen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         obs_cyc++;
         chk("en_exclusive", {31'b0, mem_r_en & mem_w_en}, 32'd0);
         chk("ready_onehot", {31'b0, &ready}, 32'd0);
         if (mem_r_en) obs_ren++;
         if (mem_w_en) obs_wen++;
         if (ready != 2'b00) begin
            obs_rdy = ready;
            obs_err = err;
            break;
         end
      end
   endtask

   task automatic check_pop();
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "_ready"},   {30'b0, obs_rdy}, {30'b0, e.rdy});
      chk({e.tag, "_err"},     {30'b0, obs_err}, {30'b0, e.er});
      chk({e.tag, "_rdata"},   rdata, e.rd);
      chk({e.tag, "_latency"}, obs_cyc, e.lat);
      chk({e.tag, "_r_en_cyc"}, obs_ren, e.ren);
      chk({e.tag, "_w_en_cyc"}, obs_wen, e.wen);
      $display("txn %s: ready=%b err=%b rdata=0x%08h latency=%0d r_en=%0d w_en=%0d",
               e.tag, obs_rdy, obs_err, rdata, obs_cyc, obs_ren, obs_wen);
   endtask

   task automatic release_req();
      req = 2'b00;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; req = 2'b00; we = 2'b00; adr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready",     {30'b0, ready}, 32'd0);
      chk("rst_err",       {30'b0, err},   32'd0);
      chk("rst_rdata",     rdata,          32'd0);
      chk("rst_r_en",      {31'b0, mem_r_en}, 32'd0);
      chk("rst_w_en",      {31'b0, mem_w_en}, 32'd0);
      chk("rst_mem_adr",   mem_adr,        32'd0);
      chk("rst_mem_wdata", mem_wdata,      32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single read by requester 0.
      drive_one(0, 1'b0, 32'd1028, 32'd0);
      push_exp("rd0_1028", 2'b01, 2'b00, 32'hDEADBEEF, 5, 4, 0);
      wait_ready(); check_pop(); release_req();

      // Requester 1 writes then reads back; the write leaves rdata alone.
      drive_one(1, 1'b1, 32'd1024, 32'h12345678);
      push_exp("wr1_1024", 2'b10, 2'b00, 32'hDEADBEEF, 5, 0, 4);
      wait_ready(); check_pop(); release_req();
      drive_one(1, 1'b0, 32'd1024, 32'd0);
      push_exp("rd1_1024", 2'b10, 2'b00, 32'h12345678, 5, 4, 0);
      wait_ready(); check_pop(); release_req();

      // Both requesting continuously: grants alternate starting with requester 0.
      req = 2'b11; we = 2'b00; adr = {32'd1024, 32'd1028}; wdata = '0;
      push_exp("rr_a0", 2'b01, 2'b00, 32'hDEADBEEF, 5, 4, 0);
      push_exp("rr_a1", 2'b10, 2'b00, 32'h12345678, 6, 4, 0);
      push_exp("rr_a2", 2'b01, 2'b00, 32'hDEADBEEF, 6, 4, 0);
      push_exp("rr_a3", 2'b10, 2'b00, 32'h12345678, 6, 4, 0);
      for (int k = 0; k < 4; k++) begin
         wait_ready(); check_pop();
      end
      release_req();

      // Illegal addresses: below base, past end, misaligned.
      drive_one(0, 1'b0, 32'd1020, 32'd0);
      push_exp("err0_1020", 2'b01, 2'b01, 32'h12345678, 1, 0, 0);
      wait_ready(); check_pop(); release_req();
      drive_one(1, 1'b1, 32'd2048, 32'h0BADF00D);
      push_exp("err1_2048", 2'b10, 2'b10, 32'h12345678, 1, 0, 0);
      wait_ready(); check_pop(); release_req();
      drive_one(0, 1'b0, 32'd1026, 32'd0);
      push_exp("err0_1026", 2'b01, 2'b01, 32'h12345678, 1, 0, 0);
      wait_ready(); check_pop(); release_req();

      // Reset in the second cycle of a write by requester 0.
      drive_one(0, 1'b1, 32'd1032, 32'hCAFEF00D);
      @(negedge clk);
      chk("abort_w_en_c1", {31'b0, mem_w_en}, 32'd1);
      @(negedge clk);
      chk("abort_w_en_c2", {31'b0, mem_w_en}, 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_w_en_fall", {31'b0, mem_w_en}, 32'd0);
      chk("abort_mem_adr",   mem_adr, 32'd0);
      chk("abort_rdata",     rdata,   32'd0);
      req = 2'b00;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("abort_no_ready", {30'b0, ready}, 32'd0);
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_rst_no_ready", {30'b0, ready}, 32'd0);
      end
      $display("txn abort_wr0_1032: reset mid-write, no ready observed");

      req = 2'b11; we = 2'b00; adr = {32'd1024, 32'd1028}; wdata = '0;
      push_exp("post_rst_rr", 2'b01, 2'b00, 32'hDEADBEEF, 5, 4, 0);
      wait_ready(); check_pop(); release_req();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters (name, default, meaning): BASE_ADR, 1024, first byte address of data memory.
REQ-002 MEM_BYTES, 1024, data memory size in bytes.
REQ-003 WAIT_CYCLES, 4, cycles each access holds the memory enable; legal range 1..15.
REQ-004 Ports (name, direction, width, meaning): clk, in, 1, single clock; all state on posedge.
REQ-005 rst, in, 1, asynchronous active-high reset.
REQ-006 req, in, 2, per-requester access request; bit i belongs to requester i.
REQ-007 we, in, 2, per-requester write select (1 = write, 0 = read).
REQ-008 adr, in, 64, byte addresses, {adr1, adr0}, 32 bits each.
REQ-009 wdata, in, 64, write data, {wdata1, wdata0}.
REQ-010 ready, out, 2, one-cycle completion pulse to the granted requester.
REQ-011 err, out, 2, one-cycle error pulse, coincident with ready.
REQ-012 rdata, out, 32, read data; valid when ready pulses for a read; held otherwise.
REQ-013 mem_adr / mem_wdata, out, 32 each, address and write data to the data memory.
REQ-014 mem_r_en / mem_w_en, out, 1 each, memory enables; never both high.
REQ-015 mem_rdata, in, 32, memory read data; updates on negedge while mem_r_en is high.

Function
REQ-016 States are IDLE, ACCESS, DONE and ERR.
- IDLE: with no req, stay IDLE.
- IDLE: with any req, grant one requester and latch its adr, wdata and we.
- IDLE, checked address legal: go to ACCESS with cnt = WAIT_CYCLES-1.
- IDLE, checked address illegal: go to ERR.
REQ-017 Arbitration is round-robin. When both requests are high, the requester not granted last wins. After reset, requester 0 has priority.
REQ-018 An address is illegal if any of these holds:
- adr < BASE_ADR
- adr > BASE_ADR+MEM_BYTES-4
- adr[1:0] != 0
REQ-019 ACCESS behaviour:
- mem_r_en or mem_w_en (per the latched we) is asserted for exactly WAIT_CYCLES cycles.
- mem_adr and mem_wdata come from the latched values and stay stable.
- cnt decrements each cycle; at cnt = 0 the block moves to DONE.
- On the final ACCESS edge of a read, rdata captures mem_rdata.
REQ-020 DONE: ready[g] = 1 for one cycle, enables low, then return to IDLE.
REQ-021 ERR: ready[g] = 1 and err[g] = 1 for one cycle; no memory enable is ever asserted; then return to IDLE.
REQ-022 Latency: ready pulses in the (WAIT_CYCLES+1)th cycle after the accepting edge. At most one grant can be accepted every WAIT_CYCLES+2 cycles.
REQ-023 A requester holds req, we, adr and wdata until its ready pulse. Deasserting req mid-access does not abort the access; the ready pulse still occurs.
REQ-024 A new request is sampled only in IDLE. A request that rises during ACCESS, DONE or ERR waits.
REQ-025 Writes leave rdata unchanged.

Reset
REQ-026 While rst is high, asynchronously:
- state = IDLE, cnt = 0, last-grant = 1 (requester 0 first).
- ready = 0, err = 0, rdata = 0.
- mem_r_en = 0, mem_w_en = 0, mem_adr = 0, mem_wdata = 0.
REQ-027 Reset asserted mid-ACCESS drops the enables immediately. The aborted access produces no ready pulse.

Structure
REQ-028 A shared package holds the state encoding (2-bit enum), the BASE_ADR/MEM_BYTES defaults and the cnt width constant (4).
REQ-029 Round-robin selection lives in one sub-module rr_arb2 (req[1:0], last -> grant[1:0]), purely combinational. The last-grant register stays in dmem_arbiter.

Verification
REQ-030 Single read, requester 0, adr=1028, WAIT_CYCLES=4, memory word 0xDEADBEEF -> mem_r_en high exactly 4 cycles; ready=2'b01 in cycle 5 after acceptance; rdata=0xDEADBEEF; err=0.
REQ-031 Write then read, requester 1 writes 0x12345678 to 1024, then reads 1024 -> mem_w_en high 4 cycles; the read returns 0x12345678 with ready=2'b10.
REQ-032 Simultaneous requests, req=2'b11 held -> grants alternate 0,1,0,1 across four accesses; never two ready bits in one cycle.
REQ-033 Illegal addresses 1020, 2048 and 1026 -> each gives ready and err pulse together one cycle after acceptance; mem_r_en and mem_w_en stay 0 throughout.
REQ-034 rst asserted in the 2nd ACCESS cycle of a write -> mem_w_en falls immediately; no ready pulse; after release, req=2'b11 grants requester 0 first.
